// File: rtl/mult4x4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult4x4_pkg                                                  |
// | Description : State encoding, select constants and output decode shared   |
// |               by the 4x4 shift-add multiplier sequencing controller.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mult4x4_pkg;

    // One-hot, so corrupted encodings are detectable and fall into default.
    typedef enum logic [7:0] {
        IDLE = 8'b0000_0001,
        CLR  = 8'b0000_0010,
        LOAD = 8'b0000_0100,
        P3   = 8'b0000_1000,
        P2   = 8'b0001_0000,
        P1   = 8'b0010_0000,
        P0   = 8'b0100_0000,
        DONE = 8'b1000_0000
    } state_t;

    localparam logic SEL_HI   = 1'b1;
    localparam logic SEL_LO   = 1'b0;
    localparam logic FB_SHIFT = 1'b0;
    localparam logic FB_HOLD  = 1'b1;

    typedef struct packed {
        logic busy;
        logic done;
        logic clr;
        logic ld_1;
        logic ld_2;
        logic s0;
        logic s1;
        logic s2;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            CLR: begin
                c.busy = 1'b1;
                c.clr  = 1'b1;
            end
            LOAD: begin
                c.busy = 1'b1;
                c.ld_1 = 1'b1;
            end
            P3: begin
                c.busy = 1'b1;
                c.ld_2 = 1'b1;
                c.s0   = SEL_HI;
                c.s1   = SEL_HI;
                c.s2   = FB_SHIFT;
            end
            P2: begin
                c.busy = 1'b1;
                c.ld_2 = 1'b1;
                c.s0   = SEL_HI;
                c.s1   = SEL_LO;
                c.s2   = FB_SHIFT;
            end
            P1: begin
                c.busy = 1'b1;
                c.ld_2 = 1'b1;
                c.s0   = SEL_LO;
                c.s1   = SEL_HI;
                c.s2   = FB_HOLD;
            end
            P0: begin
                c.busy = 1'b1;
                c.ld_2 = 1'b1;
                c.s0   = SEL_LO;
                c.s1   = SEL_LO;
                c.s2   = FB_SHIFT;
            end
            DONE: begin
                c.busy = 1'b1;
                c.done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult4x4_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult4x4_seq_ctrl                                             |
// | Description : Moore sequencer driving the 4x4 shift-add multiplier         |
// |               datapath (clear, operand load, four partial-product steps).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mult4x4_seq_ctrl
    import mult4x4_pkg::*;
#(
    parameter logic DP_RST_ACTIVE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic dp_rst,
    output logic ld_1,
    output logic ld_2,
    output logic s0,
    output logic s1,
    output logic s2
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = start ? CLR : IDLE;
            CLR:     w_next = LOAD;
            LOAD:    w_next = P3;
            P3:      w_next = P2;
            P2:      w_next = P1;
            P1:      w_next = P0;
            P0:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode, so each output flop
    // always equals decode_ctrl(r_state) and is free of combinational glitches.
    assign w_ctrl = decode_ctrl(w_next);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            dp_rst  <= ~DP_RST_ACTIVE;
            ld_1    <= 1'b0;
            ld_2    <= 1'b0;
            s0      <= 1'b0;
            s1      <= 1'b0;
            s2      <= 1'b0;
        end else begin
            r_state <= w_next;
            busy    <= w_ctrl.busy;
            done    <= w_ctrl.done;
            dp_rst  <= w_ctrl.clr ? DP_RST_ACTIVE : ~DP_RST_ACTIVE;
            ld_1    <= w_ctrl.ld_1;
            ld_2    <= w_ctrl.ld_2;
            s0      <= w_ctrl.s0;
            s1      <= w_ctrl.s1;
            s2      <= w_ctrl.s2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult4x4_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mult4x4_seq_ctrl                                          |
// | Description : Directed bench for mult4x4_seq_ctrl with a behavioural       |
// |               shift-add datapath attached to its control outputs.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mult4x4_seq_ctrl;

    logic clk;
    logic rst;
    logic start;
    logic busy, done, dp_rst, ld_1, ld_2, s0, s1, s2;

    logic [3:0] a, b;
    logic [3:0] ra, rb;
    logic [7:0] out;
    logic [1:0] ha, hb;
    logic [7:0] pp;

    int n_pass;
    int n_total;

    mult4x4_seq_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .dp_rst (dp_rst),
        .ld_1   (ld_1),
        .ld_2   (ld_2),
        .s0     (s0),
        .s1     (s1),
        .s2     (s2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: 2x2 multiplier on the selected halves, 8-bit adder, accumulator.
    assign ha = s0 ? ra[3:2] : ra[1:0];
    assign hb = s1 ? rb[3:2] : rb[1:0];
    assign pp = {6'd0, ha} * {6'd0, hb};

    initial begin
        ra  = 4'd0;
        rb  = 4'd0;
        out = 8'd0;
    end

    always @(posedge clk) begin
        if (dp_rst) begin
            ra  <= 4'd0;
            rb  <= 4'd0;
            out <= 8'd0;
        end else begin
            if (ld_1) begin
                ra <= a;
                rb <= b;
            end
            if (ld_2)
                out <= (s2 ? out : {out[5:0], 2'b00}) + pp;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic issue_start(input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({busy, done, ld_1, ld_2, s0, s1, s2} !== 7'd0)
            $display("FAIL reset_outputs: got %b expected %b", {busy, done, ld_1, ld_2, s0, s1, s2}, 7'd0);
        else n_pass++;
        n_total++;
        if (dp_rst !== 1'b0)
            $display("FAIL reset_dp_rst: got %b expected %b", dp_rst, 1'b0);
        else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL idle_after_release: got busy=%b expected %b", busy, 1'b0);
        else n_pass++;
    endtask

    task automatic test_max();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        logic [7:0] out_at_done = 8'h00;
        issue_start(4'hF, 4'hF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at     = i;
                out_at_done = out;
            end
        end
        n_total++;
        if (done_at !== 6)
            $display("FAIL max_latency: got done at cycle %0d expected %0d", done_at, 6);
        else n_pass++;
        n_total++;
        if (done_cnt !== 1)
            $display("FAIL max_done_count: got %0d expected %0d", done_cnt, 1);
        else n_pass++;
        n_total++;
        if (busy_cnt !== 7)
            $display("FAIL max_busy_cycles: got %0d expected %0d", busy_cnt, 7);
        else n_pass++;
        n_total++;
        if (out_at_done !== 8'hE1)
            $display("FAIL max_product: got %h expected %h", out_at_done, 8'hE1);
        else n_pass++;
    endtask

    task automatic test_clear();
        logic [7:0] out_load = 8'hFF;
        logic [7:0] out_done = 8'hFF;
        logic       done_ok  = 1'b0;
        n_total++;
        if (out !== 8'hE1)
            $display("FAIL clear_stale_hold: got %h expected %h", out, 8'hE1);
        else n_pass++;
        issue_start(4'h0, 4'hD);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) out_load = out;
            if (i == 6) begin
                out_done = out;
                done_ok  = done;
            end
        end
        n_total++;
        if (out_load !== 8'h00)
            $display("FAIL clear_acc_after_clr: got %h expected %h", out_load, 8'h00);
        else n_pass++;
        n_total++;
        if (done_ok !== 1'b1 || out_done !== 8'h00)
            $display("FAIL clear_product: got done=%b out=%h expected done=1 out=%h", done_ok, out_done, 8'h00);
        else n_pass++;
    endtask

    task automatic test_trace();
        // {dp_rst, ld_1, ld_2, s0, s1, s2, done, busy} per cycle after the accepting edge
        logic [7:0] exp_tab [8] = '{8'b1000_0001, 8'b0100_0001, 8'b0011_1001, 8'b0011_0001,
                                    8'b0010_1101, 8'b0010_0001, 8'b0000_0011, 8'b0000_0000};
        logic [7:0] obs;
        int ld1_cnt = 0;
        int ld2_cnt = 0;
        issue_start(4'h9, 4'h6);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            obs = {dp_rst, ld_1, ld_2, s0, s1, s2, done, busy};
            if (ld_1) ld1_cnt++;
            if (ld_2) ld2_cnt++;
            n_total++;
            if (obs !== exp_tab[i])
                $display("FAIL trace[%0d]: got %b expected %b", i, obs, exp_tab[i]);
            else n_pass++;
        end
        n_total++;
        if (ld1_cnt !== 1 || ld2_cnt !== 4)
            $display("FAIL trace_load_counts: got ld_1=%0d ld_2=%0d expected 1 and 4", ld1_cnt, ld2_cnt);
        else n_pass++;
        n_total++;
        if (out !== 8'h36)
            $display("FAIL trace_product: got %h expected %h", out, 8'h36);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        int first_at = -1;
        int second_at = -1;
        logic [7:0] out1 = 8'h00;
        logic [7:0] out2 = 8'h00;
        logic drained = 1'b0;
        @(negedge clk);
        a     = 4'h3;
        b     = 4'h5;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (first_at < 0) begin
                    first_at = i;
                    out1     = out;
                end else begin
                    second_at = i;
                    out2      = out;
                end
            end
        end
        start = 1'b0;
        n_total++;
        if (done_cnt !== 2)
            $display("FAIL b2b_done_count: got %0d expected %0d", done_cnt, 2);
        else n_pass++;
        n_total++;
        if (first_at !== 6 || second_at !== 14)
            $display("FAIL b2b_done_spacing: got cycles %0d,%0d expected 6,14", first_at, second_at);
        else n_pass++;
        n_total++;
        if (out1 !== 8'h0F || out2 !== 8'h0F)
            $display("FAIL b2b_product: got %h,%h expected %h,%h", out1, out2, 8'h0F, 8'h0F);
        else n_pass++;
        // A third operation was accepted before start dropped; let it finish.
        for (int i = 0; i < 20 && !drained; i++) begin
            @(negedge clk);
            if (!busy && !done) drained = 1'b1;
        end
        n_total++;
        if (drained !== 1'b1)
            $display("FAIL b2b_drain: got busy=%b expected %b", busy, 1'b0);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int done_cnt = 0;
        int done_at  = -1;
        logic [7:0] out_done = 8'h00;
        issue_start(4'h7, 4'h7);
        repeat (4) @(negedge clk);
        n_total++;
        if ({ld_2, s0, s1, s2} !== 4'b1100)
            $display("FAIL arst_in_p2: got %b expected %b", {ld_2, s0, s1, s2}, 4'b1100);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if ({busy, done, ld_1, ld_2, s0, s1, s2, dp_rst} !== 8'd0)
            $display("FAIL arst_immediate: got %b expected %b", {busy, done, ld_1, ld_2, s0, s1, s2, dp_rst}, 8'd0);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        n_total++;
        if (done_cnt !== 0)
            $display("FAIL arst_abandoned: got %0d active cycles expected %0d", done_cnt, 0);
        else n_pass++;
        done_cnt = 0;
        issue_start(4'h7, 4'h7);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_at  = i;
                out_done = out;
            end
        end
        n_total++;
        if (done_cnt !== 1 || done_at !== 6)
            $display("FAIL arst_restart_done: got count=%0d at=%0d expected 1 at 6", done_cnt, done_at);
        else n_pass++;
        n_total++;
        if (out_done !== 8'h31)
            $display("FAIL arst_restart_product: got %h expected %h", out_done, 8'h31);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_max();
        test_clear();
        test_trace();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
